chan_router: RTL and testbench
==============================

CHAN_ROUTER -- requirements
Module: chan_router

Interface
REQ-001 Parameter NCH, default 4, number of source channels and destination channels (2..16).
REQ-002 Parameter W, default 4, data width per channel in bits.
REQ-003 Parameter SCAN_DIV, default 50_000_000, clk cycles per auto-scan step (>=2).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  NCH*W  packed sources; channel k at bits [k*W +: W].
REQ-007 src_sel  input  SW=$clog2(NCH)  requested source index.
REQ-008 dst_sel  input  SW  requested destination index.
REQ-009 load  input  1  selection capture request; level input, rising edge is significant.
REQ-010 enable  input  1  routing enable; low forces IDLE.
REQ-011 mode  input  1  0 = manual, 1 = auto-scan.
REQ-012 data_out  output  NCH*W  packed destinations, registered.
REQ-013 active_src, active_dst  output  SW each  currently applied selection, registered.
REQ-014 sel_err  output  1  one-cycle pulse on a rejected manual load.

Function
REQ-015 The block SHALL implement states IDLE, MANUAL and SCAN.
REQ-016 Transitions: any state with enable=0 -> IDLE; IDLE with enable=1 -> MANUAL if mode=0, SCAN if mode=1; MANUAL<->SCAN follows mode while enable=1; each transition takes one cycle.
REQ-017 Load edge = load high this cycle and low the previous cycle; the previous-load register SHALL update in every state.
REQ-018 In MANUAL, on a load edge with src_sel<NCH and dst_sel<NCH, active_src/active_dst SHALL take src_sel/dst_sel on the next edge.
REQ-019 In MANUAL, on a load edge with either index >=NCH, the selection SHALL be unchanged and sel_err SHALL pulse high for exactly one cycle.
REQ-020 In SCAN, a step tick SHALL occur every SCAN_DIV cycles, the divider restarting at 0 on each entry to SCAN; load edges are ignored.
REQ-021 On each tick active_src SHALL increment modulo NCH; when it wraps from NCH-1 to 0, active_dst SHALL increment modulo NCH in the same cycle.
REQ-022 A mode change SHALL keep the current active_src/active_dst; SCAN->MANUAL freezes them, MANUAL->SCAN resumes stepping from them.
REQ-023 In MANUAL and SCAN, destination active_dst SHALL receive data_in channel active_src with one-cycle latency from data_in or selection change.
REQ-024 In IDLE, all data_out SHALL be 0 from the cycle after entry; selection and divider SHALL be frozen.
REQ-025 Unselected destinations SHALL behave per REQ-029/REQ-030.

Reset
REQ-026 Reset SHALL force state IDLE, data_out 0, active_src 0, active_dst 0, sel_err 0, divider 0, previous-load 0, independent of clk.
REQ-027 Reset asserted mid-scan or mid-load SHALL discard the pending step/capture; after release a load held high SHALL NOT count as an edge until it goes low and high again.

Configuration
REQ-028 Macro CHAN_ROUTER_HOLD_EN SHALL select destination hold behaviour.
REQ-029 With CHAN_ROUTER_HOLD_EN defined, unselected destinations SHALL retain their last routed value while in MANUAL/SCAN.
REQ-030 Without it, unselected destinations SHALL be driven 0 each cycle (plain demux behaviour).

Structure
REQ-031 Package router_pkg SHALL hold the state enum (IDLE, MANUAL, SCAN), the mode encoding constants and a width helper for SW.
REQ-032 A sub-module scan_tick SHALL generate the SCAN_DIV step tick with clear and enable inputs; all else resides in chan_router.

Verification (NCH=4, W=4, SCAN_DIV=4)
REQ-033 Reset release, enable=0 -> data_out=16'h0000, active_src=0, active_dst=0, sel_err=0.
REQ-034 data_in=16'hDCBA, enable=1, mode=0, load edge with src=2, dst=1 -> after 2 cycles active_src=2, active_dst=1, data_out[7:4]=4'hC; data_in channel 2 -> 4'h5 gives data_out[7:4]=5 one cycle later.
REQ-035 Then load edge src=3, dst=3 -> data_out[15:12]=4'hD; data_out[7:4]=4'hC with HOLD_EN, 0 without.
REQ-036 NCH=3 build, load edge with src_sel=3 -> sel_err high exactly one cycle, active_src unchanged.
REQ-037 mode=1 from src=3, dst=0 -> after 4 cycles src=0, dst=1; after 8 more src=2, dst=1; load edges ignored.
REQ-038 Reset asserted mid-SCAN with load held high -> all outputs 0 immediately; no capture after release until load toggles low then high.

Source files
------------

// File: rtl/chan_router_pkg.sv
// rtl/chan_router_pkg.sv - shared types, mode encoding and width helper for chan_router
//
// Package router_pkg
//   routerState_e : router FSM states (IDLE, MANUAL, SCAN)
//   MODE_MANUAL / MODE_SCAN : encoding of the mode input
//   selWidth()    : bit width of a channel index for a given channel count
package router_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } routerState_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // A one-channel router would need a zero-width index; keep at least 1 bit.
  function automatic int selWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chan_router_if.sv
// rtl/chan_router_if.sv - data/selection/status bundle between a router and its user
//
// Interface chan_router_if #(NCH, W)
//   data_in    [NCH*W] packed sources, channel k at [k*W +: W]
//   src_sel    [SW]    requested source index
//   dst_sel    [SW]    requested destination index
//   load               selection capture request (rising edge significant)
//   enable             routing enable
//   mode               MODE_MANUAL / MODE_SCAN
//   data_out   [NCH*W] packed destinations
//   active_src [SW]    applied source index
//   active_dst [SW]    applied destination index
//   sel_err            one-cycle pulse on a rejected manual load
// Modports: master (drives requests, observes results), slave (the router).
interface chan_router_if
  import router_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 4
);
  localparam int SW = selWidth(NCH);

  logic [NCH*W-1:0] data_in;
  logic [SW-1:0]    src_sel;
  logic [SW-1:0]    dst_sel;
  logic             load;
  logic             enable;
  logic             mode;
  logic [NCH*W-1:0] data_out;
  logic [SW-1:0]    active_src;
  logic [SW-1:0]    active_dst;
  logic             sel_err;

  modport master (
    output data_in, src_sel, dst_sel, load, enable, mode,
    input  data_out, active_src, active_dst, sel_err
  );

  modport slave (
    input  data_in, src_sel, dst_sel, load, enable, mode,
    output data_out, active_src, active_dst, sel_err
  );

endinterface

// File: rtl/chan_router_scan_tick.sv
// rtl/chan_router_scan_tick.sv - auto-scan step divider for chan_router
//
// Module scan_tick #(SCAN_DIV)
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset, counter to 0
//   clear  : synchronous restart of the divider at 0 (wins over enable)
//   enable : count this cycle
//   tick   : high during the last cycle of each SCAN_DIV-cycle period while enabled
module scan_tick #(
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);

  logic [CW-1:0] divCnt;

  assign tick = enable && (divCnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt <= '0;
    end else if (clear) begin
      divCnt <= '0;
    end else if (enable) begin
      if (tick) begin
        divCnt <= '0;
      end else begin
        divCnt <= divCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_router.sv
// rtl/chan_router.sv - NCH-channel source-to-destination router with manual and auto-scan selection
//
// Module chan_router #(NCH, W, SCAN_DIV)
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : chan_router_if.slave (data_in, src_sel, dst_sel, load, enable, mode in;
//           data_out, active_src, active_dst, sel_err out, all outputs registered)
// Build option CHAN_ROUTER_HOLD_EN: when defined, destinations that are not selected keep
// their last routed value while routing; otherwise they are driven 0 every cycle.
module chan_router
  import router_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int W        = 4,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic          clk,
  input  logic          reset,
  chan_router_if.slave  bus
);

  localparam int SW = selWidth(NCH);

  routerState_e     state;
  logic             loadPrev;
  logic [SW-1:0]    activeSrc;
  logic [SW-1:0]    activeDst;
  logic             selErr;
  logic [NCH*W-1:0] dataOutQ;

  logic             loadEdge;
  logic             selValid;
  logic             scanClear;
  logic             scanEn;
  logic             scanTick;
  logic             srcWrap;
  logic             dstWrap;
  logic [W-1:0]     srcWord;

  assign loadEdge = bus.load && !loadPrev;
  // SW bits can encode indices beyond NCH-1 when NCH is not a power of two.
  assign selValid = (int'(bus.src_sel) < NCH) && (int'(bus.dst_sel) < NCH);

  // The divider restarts on the cycle the FSM commits to entering SCAN, and only runs
  // while the FSM stays in SCAN, so a tick never lands on an exit cycle.
  assign scanClear = (state != SCAN) && bus.enable && (bus.mode == MODE_SCAN);
  assign scanEn    = (state == SCAN) && bus.enable && (bus.mode == MODE_SCAN);

  assign srcWrap = (activeSrc == SW'(NCH - 1));
  assign dstWrap = (activeDst == SW'(NCH - 1));

  scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanTick (
    .clk    (clk),
    .reset  (reset),
    .clear  (scanClear),
    .enable (scanEn),
    .tick   (scanTick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      loadPrev  <= 1'b0;
      activeSrc <= '0;
      activeDst <= '0;
      selErr    <= 1'b0;
    end else begin
      // Tracked in every state so a load held through IDLE is not seen as an edge later.
      loadPrev <= bus.load;
      selErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state <= (bus.mode == MODE_SCAN) ? SCAN : MANUAL;
          end
        end
        MANUAL: begin
          if (!bus.enable) begin
            state <= IDLE;
          end else if (bus.mode == MODE_SCAN) begin
            state <= SCAN;
          end else if (loadEdge) begin
            if (selValid) begin
              activeSrc <= bus.src_sel;
              activeDst <= bus.dst_sel;
            end else begin
              selErr <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (!bus.enable) begin
            state <= IDLE;
          end else if (bus.mode == MODE_MANUAL) begin
            state <= MANUAL;
          end else if (scanTick) begin
            activeSrc <= srcWrap ? '0 : activeSrc + 1'b1;
            if (srcWrap) begin
              activeDst <= dstWrap ? '0 : activeDst + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    srcWord = '0;
    for (int j = 0; j < NCH; j++) begin
      if (SW'(j) == activeSrc) begin
        srcWord = bus.data_in[j*W +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOutQ <= '0;
    end else if (state == IDLE) begin
      dataOutQ <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (SW'(k) == activeDst) begin
          dataOutQ[k*W +: W] <= srcWord;
        end else begin
`ifdef CHAN_ROUTER_HOLD_EN
          dataOutQ[k*W +: W] <= dataOutQ[k*W +: W];
`else
          dataOutQ[k*W +: W] <= '0;
`endif
        end
      end
    end
  end

  assign bus.data_out   = dataOutQ;
  assign bus.active_src = activeSrc;
  assign bus.active_dst = activeDst;
  assign bus.sel_err    = selErr;

endmodule

// File: tb/tb_chan_router.sv
// tb/tb_chan_router.sv - scoreboard bench for chan_router (NCH=4 and NCH=3 instances)
module tb_chan_router;
  import router_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  chan_router_if #(.NCH(4), .W(4)) busA ();
  chan_router_if #(.NCH(3), .W(4)) busB ();

  chan_router #(.NCH(4), .W(4), .SCAN_DIV(4)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  chan_router #(.NCH(3), .W(4), .SCAN_DIV(4)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  localparam int K_DOUT = 0;
  localparam int K_NIB  = 1;
  localparam int K_SRC  = 2;
  localparam int K_DST  = 3;
  localparam int K_ERR  = 4;
  localparam int K_SRCB = 5;
  localparam int K_ERRB = 6;

  typedef struct {
    string tag;
    int    kind;
    int    idx;
    int    exp;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  failures = 0;

  task automatic checkVal(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int observe(input int kind, input int idx);
    case (kind)
      K_DOUT:  return int'(busA.data_out);
      K_NIB:   return int'(busA.data_out[idx*4 +: 4]);
      K_SRC:   return int'(busA.active_src);
      K_DST:   return int'(busA.active_dst);
      K_ERR:   return int'(busA.sel_err);
      K_SRCB:  return int'(busB.active_src);
      K_ERRB:  return int'(busB.sel_err);
      default: return -1;
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input int idx, input int exp);
    expT e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    expQ.push_back(e);
  endtask

  task automatic drain();
    expT e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkVal(e.tag, observe(e.kind, e.idx), e.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    busA.data_in = '0; busA.src_sel = '0; busA.dst_sel = '0;
    busA.load = 1'b0; busA.enable = 1'b0; busA.mode = MODE_MANUAL;
    busB.data_in = '0; busB.src_sel = '0; busB.dst_sel = '0;
    busB.load = 1'b0; busB.enable = 1'b0; busB.mode = MODE_MANUAL;

    step(2);
    reset = 1'b0;
    step(1);
    push("rst_dout", K_DOUT, 0, 'h0000);
    push("rst_src", K_SRC, 0, 0);
    push("rst_dst", K_DST, 0, 0);
    push("rst_err", K_ERR, 0, 0);
    drain();

    // Manual routing 2 -> 1
    busA.data_in = 16'hDCBA;
    busA.enable = 1'b1;
    busA.mode = MODE_MANUAL;
    busB.data_in = 12'h321;
    busB.enable = 1'b1;
    step(1);
    busA.src_sel = 2'd2; busA.dst_sel = 2'd1; busA.load = 1'b1;
    step(1);
    busA.load = 1'b0;
    step(1);
    push("man_src", K_SRC, 0, 2);
    push("man_dst", K_DST, 0, 1);
    push("man_nib1", K_NIB, 1, 'hC);
    drain();

    busA.data_in = 16'hD5BA;
    step(1);
    push("man_nib1_follow", K_NIB, 1, 'h5);
    push("man_dout_full", K_DOUT, 0, 'h0050);
    drain();

    // Reselect 3 -> 3; destination 1 holds or clears depending on the build
    busA.data_in = 16'hDCBA;
    busA.src_sel = 2'd3; busA.dst_sel = 2'd3; busA.load = 1'b1;
    step(1);
    busA.load = 1'b0;
    step(1);
    push("resel_nib3", K_NIB, 3, 'hD);
`ifdef CHAN_ROUTER_HOLD_EN
    push("resel_nib1", K_NIB, 1, 'hC);
`else
    push("resel_nib1", K_NIB, 1, 'h0);
`endif
    drain();

    // Position for scan: 3 -> 0
    busA.src_sel = 2'd3; busA.dst_sel = 2'd0; busA.load = 1'b1;
    step(1);
    busA.load = 1'b0;
    step(1);
    push("pre_scan_src", K_SRC, 0, 3);
    push("pre_scan_dst", K_DST, 0, 0);
    push("pre_scan_nib0", K_NIB, 0, 'hD);
    drain();

    // NCH=3 instance: valid load then out-of-range loads
    busB.src_sel = 2'd1; busB.dst_sel = 2'd2; busB.load = 1'b1;
    step(1);
    busB.load = 1'b0;
    step(1);
    push("b_valid_src", K_SRCB, 0, 1);
    push("b_valid_err", K_ERRB, 0, 0);
    drain();
    busB.src_sel = 2'd3; busB.dst_sel = 2'd0; busB.load = 1'b1;
    step(1);
    push("b_bad_src_err", K_ERRB, 0, 1);
    push("b_bad_src_keep", K_SRCB, 0, 1);
    drain();
    step(1);
    push("b_err_one_cycle", K_ERRB, 0, 0);
    push("b_src_still", K_SRCB, 0, 1);
    drain();
    busB.load = 1'b0;
    step(1);
    busB.src_sel = 2'd0; busB.dst_sel = 2'd3; busB.load = 1'b1;
    step(1);
    push("b_bad_dst_err", K_ERRB, 0, 1);
    push("b_bad_dst_keep", K_SRCB, 0, 1);
    drain();
    busB.load = 1'b0;

    // Auto-scan from 3 -> 0; load edges during scan must be ignored
    busA.mode = MODE_SCAN;
    step(1);
    busA.src_sel = 2'd1; busA.dst_sel = 2'd2; busA.load = 1'b1;
    step(2);
    busA.load = 1'b0;
    step(2);
    push("scan1_src", K_SRC, 0, 0);
    push("scan1_dst", K_DST, 0, 1);
    drain();
    step(8);
    push("scan3_src", K_SRC, 0, 2);
    push("scan3_dst", K_DST, 0, 1);
    drain();
    step(1);
    push("scan_nib1", K_NIB, 1, 'hC);
`ifdef CHAN_ROUTER_HOLD_EN
    push("scan_nib0", K_NIB, 0, 'hD);
`else
    push("scan_nib0", K_NIB, 0, 'h0);
`endif
    drain();

    // Disable: outputs clear, selection frozen
    busA.enable = 1'b0;
    step(2);
    push("idle_dout", K_DOUT, 0, 'h0000);
    push("idle_src", K_SRC, 0, 2);
    drain();
    step(6);
    push("idle_src_frozen", K_SRC, 0, 2);
    drain();

    // Reset mid-scan with load held high
    busA.enable = 1'b1;
    busA.mode = MODE_SCAN;
    busA.load = 1'b1;
    step(3);
    #2;
    reset = 1'b1;
    #1;
    push("async_rst_dout", K_DOUT, 0, 'h0000);
    push("async_rst_src", K_SRC, 0, 0);
    push("async_rst_dst", K_DST, 0, 0);
    push("async_rst_err", K_ERR, 0, 0);
    drain();
    #3;
    reset = 1'b0;
    busA.mode = MODE_MANUAL;
    busA.src_sel = 2'd2; busA.dst_sel = 2'd3;
    step(4);
    push("held_load_src", K_SRC, 0, 0);
    push("held_load_dst", K_DST, 0, 0);
    drain();
    busA.load = 1'b0;
    step(1);
    busA.load = 1'b1;
    step(1);
    push("reload_src", K_SRC, 0, 2);
    push("reload_dst", K_DST, 0, 3);
    drain();
    busA.load = 1'b0;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
